spi_slave_byte_if: RTL

- Oversampled SPI slave (mode 0, MSB first) on the CPLD, directly downstream of the SPI pass-through.
- Consumes the buffered SPI_CLK/SPI_MOSI/SPI_NSS lines from the Raspberry Pi and returns SPI_MISO.
- Deserialises received bytes into a valid/ready stream and serialises a byte supplied by local logic.
- All SPI inputs are asynchronous to CLK and are synchronised inside the block.

---
 rtl/spi_cpld_pkg.sv | 13 +
 rtl/spi_slave_byte_if_sync_edge.sv | 24 ++
 rtl/spi_slave_byte_if.sv | 145 ++++++++++++++
 3 files changed

// File: rtl/spi_cpld_pkg.sv
// Shared constants for the CPLD SPI slave path: word width, FSM encoding and
// the reset presets of the input synchronisers.
package spi_cpld_pkg;
  localparam int DATA_W_DEF = 8;
  localparam int RX_COUNT_W = 8;

  typedef enum logic {ST_IDLE = 1'b0, ST_SHIFT = 1'b1} spi_state_e;

  // Idle bus levels: reset release must not look like an edge.
  localparam logic SCLK_RST = 1'b0;
  localparam logic NSS_RST  = 1'b1;
  localparam logic MOSI_RST = 1'b0;
endpackage

// File: rtl/spi_slave_byte_if_sync_edge.sv
// spi_sync_edge: STAGES-deep synchroniser with a reset preset and rise/fall
// pulses taken from the last stage against one extra delayed copy.
module spi_sync_edge #(
  parameter int   STAGES = 2,
  parameter logic INIT   = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic din,
  output logic dout,
  output logic rise,
  output logic fall
);
  logic [STAGES:0] chain;

  always_ff @(posedge clk) begin
    if (rst) chain <= {(STAGES+1){INIT}};
    else     chain <= {chain[STAGES-1:0], din};
  end

  assign dout = chain[STAGES-1];
  assign rise =  chain[STAGES-1] & ~chain[STAGES];
  assign fall = ~chain[STAGES-1] &  chain[STAGES];
endmodule

// File: rtl/spi_slave_byte_if.sv
// Oversampled SPI mode-0 slave: RX words to a valid/ready stream, TX words from
// local logic. Define SPI_SLAVE_BYTE_COUNT_EN to add the RX_COUNT output.
module spi_slave_byte_if
  import spi_cpld_pkg::*;
#(
  parameter int DATA_W      = DATA_W_DEF,
  parameter int SYNC_STAGES = 2
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              SPI_CLK,
  input  logic              SPI_MOSI,
  input  logic              SPI_NSS,
  output logic              SPI_MISO,
  output logic [DATA_W-1:0] RX_DATA,
  output logic              RX_VALID,
  input  logic              RX_READY,
  input  logic [DATA_W-1:0] TX_DATA,
  output logic              TX_REQ,
  output logic              FRAME_START,
  output logic              FRAME_END,
  output logic              OVERRUN,
  output logic              PARTIAL
`ifdef SPI_SLAVE_BYTE_COUNT_EN
  ,
  output logic [RX_COUNT_W-1:0] RX_COUNT
`endif
);
  localparam int STG   = (SYNC_STAGES < 2) ? 2 : SYNC_STAGES;
  localparam int CNT_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(DATA_W - 1);

  logic sclk_lvl, sclk_rise, sclk_fall;
  logic mosi_lvl, mosi_rise, mosi_fall;
  logic nss_lvl, nss_rise, nss_fall;

  spi_sync_edge #(.STAGES(STG), .INIT(SCLK_RST)) u_sclk (
    .clk(CLK), .rst(RST), .din(SPI_CLK), .dout(sclk_lvl), .rise(sclk_rise), .fall(sclk_fall));
  spi_sync_edge #(.STAGES(STG), .INIT(MOSI_RST)) u_mosi (
    .clk(CLK), .rst(RST), .din(SPI_MOSI), .dout(mosi_lvl), .rise(mosi_rise), .fall(mosi_fall));
  spi_sync_edge #(.STAGES(STG), .INIT(NSS_RST)) u_nss (
    .clk(CLK), .rst(RST), .din(SPI_NSS), .dout(nss_lvl), .rise(nss_rise), .fall(nss_fall));

  logic unused_sync;
  assign unused_sync = ^{sclk_lvl, mosi_rise, mosi_fall};

  spi_state_e        state;
  logic [CNT_W-1:0]  bit_cnt;
  logic [DATA_W-1:0] rx_shift, tx_shift;
  logic              tx_pend, word_done;
  // warm tracks when the NSS chain holds real samples instead of the preset;
  // a frame may only start once NSS has been seen high after reset.
  logic [STG-1:0]    warm;
  logic              armed;

  always_ff @(posedge CLK) begin
    if (RST) begin
      state       <= ST_IDLE;
      bit_cnt     <= '0;
      rx_shift    <= '0;
      tx_shift    <= '0;
      tx_pend     <= 1'b0;
      word_done   <= 1'b0;
      warm        <= '0;
      armed       <= 1'b0;
      RX_DATA     <= '0;
      RX_VALID    <= 1'b0;
      TX_REQ      <= 1'b0;
      FRAME_START <= 1'b0;
      FRAME_END   <= 1'b0;
      OVERRUN     <= 1'b0;
      PARTIAL     <= 1'b0;
`ifdef SPI_SLAVE_BYTE_COUNT_EN
      RX_COUNT    <= '0;
`endif
    end else begin
      warm <= {warm[STG-2:0], 1'b1};
      if (warm[STG-1] && nss_lvl) armed <= 1'b1;
      TX_REQ      <= 1'b0;
      FRAME_START <= 1'b0;
      FRAME_END   <= 1'b0;
      PARTIAL     <= 1'b0;
      word_done   <= 1'b0;
      case (state)
        ST_IDLE: if (nss_fall && armed) begin
          state       <= ST_SHIFT;
          FRAME_START <= 1'b1;
          tx_shift    <= TX_DATA;
          TX_REQ      <= 1'b1;
          tx_pend     <= 1'b0;
          bit_cnt     <= '0;
          OVERRUN     <= 1'b0;
`ifdef SPI_SLAVE_BYTE_COUNT_EN
          RX_COUNT    <= '0;
`endif
        end
        ST_SHIFT: begin
          // NSS rise wins over any SCLK edge in the same cycle.
          if (nss_rise) begin
            state     <= ST_IDLE;
            FRAME_END <= 1'b1;
            PARTIAL   <= (bit_cnt != '0);
            bit_cnt   <= '0;
            tx_pend   <= 1'b0;
          end else if (sclk_rise) begin
            rx_shift <= {rx_shift[DATA_W-2:0], mosi_lvl};
            if (bit_cnt == LAST) begin
              bit_cnt   <= '0;
              word_done <= 1'b1;
              tx_pend   <= 1'b1;
`ifdef SPI_SLAVE_BYTE_COUNT_EN
              if (RX_COUNT != '1) RX_COUNT <= RX_COUNT + 1'b1;
`endif
            end else begin
              bit_cnt <= bit_cnt + 1'b1;
            end
          end else if (sclk_fall) begin
            if (tx_pend) begin
              tx_shift <= TX_DATA;
              TX_REQ   <= 1'b1;
              tx_pend  <= 1'b0;
            end else begin
              tx_shift <= {tx_shift[DATA_W-2:0], 1'b0};
            end
          end
        end
        default: state <= ST_IDLE;
      endcase
      // Hand-off runs regardless of state so a word completed just before NSS
      // rises is still delivered.
      if (word_done) begin
        if (!RX_VALID || RX_READY) begin
          RX_DATA  <= rx_shift;
          RX_VALID <= 1'b1;
        end else begin
          OVERRUN  <= 1'b1;
        end
      end else if (RX_VALID && RX_READY) begin
        RX_VALID <= 1'b0;
      end
    end
  end

  assign SPI_MISO = (state == ST_SHIFT) & tx_shift[DATA_W-1];
endmodule
